// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: match controller that serves, pauses and scores the Pong subsystem.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       posEdgeScreenEnd,
  input  logic [1:0] winner,
  output logic       cpu_reset,
  output logic       frame_tick,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic [1:0] champion,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;
  state_t state, next;
  logic start_q, pause_q, start_edge, pause_edge, scored, serve_done, restart;
  logic [7:0] serve_cnt;
  logic [1:0] pt_reg;
  logic [3:0] new_score;
  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign scored     = winner == 2'b01 || winner == 2'b10;
  assign serve_done = posEdgeScreenEnd && (serve_cnt + 8'd1) == 8'(SERVE_FRAMES);
  assign restart    = start_edge && (state == IDLE || state == OVER);
  assign new_score  = (pt_reg == 2'b01 ? score_p1 : score_p2) + 4'd1;
  assign state_dbg  = state;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_edge ? SERVE : IDLE;
      SERVE:   next = serve_done ? PLAY : SERVE;
      PLAY:    next = scored ? POINT : (pause_edge ? PAUSE : PLAY);
      PAUSE:   next = pause_edge ? PLAY : PAUSE;
      POINT:   next = new_score == 4'(WIN_SCORE) ? OVER : SERVE;
      OVER:    next = start_edge ? SERVE : OVER;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      serve_cnt  <= 8'd0;
      pt_reg     <= 2'b00;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      champion   <= 2'b00;
      cpu_reset  <= 1'b1;
      frame_tick <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      start_q    <= start;
      pause_q    <= pause;
      cpu_reset  <= !(next == PLAY || next == PAUSE);
      game_over  <= next == OVER;
      frame_tick <= state == PLAY && posEdgeScreenEnd;
      if (restart) serve_cnt <= 8'd0;
      else if (state == SERVE && posEdgeScreenEnd) serve_cnt <= serve_done ? 8'd0 : serve_cnt + 8'd1;
      if (state == PLAY && scored) pt_reg <= winner;
      if (restart) begin
        score_p1 <= 4'd0;
        score_p2 <= 4'd0;
        champion <= 2'b00;
      end else if (state == POINT) begin
        if (pt_reg == 2'b01) score_p1 <= new_score;
        else score_p2 <= new_score;
        if (new_score == 4'(WIN_SCORE)) champion <= pt_reg;
      end
    end
  end
endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer: directed scenario bench for the Pong match controller.
module tb_pong_game_sequencer;
  logic       clock = 0, reset = 0, start = 0, pause = 0, pe = 0;
  logic [1:0] winner = 0;
  logic       cpu_reset, frame_tick, game_over;
  logic [3:0] score_p1, score_p2;
  logic [1:0] champion;
  logic [2:0] state_dbg;
  int n_checks = 0, n_fail = 0;

  pong_game_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .posEdgeScreenEnd(pe), .winner(winner), .cpu_reset(cpu_reset),
    .frame_tick(frame_tick), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .champion(champion), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_frame();
    pe = 1; tick(); pe = 0; tick();
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < 60; i++) pulse_frame();
  endtask

  task automatic score_point(input logic [1:0] w);
    serve_to_play();
    winner = w; tick(); winner = 0; tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if ({cpu_reset, frame_tick, score_p1, score_p2, game_over, champion, state_dbg} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values got cr=%b ft=%b s1=%0d s2=%0d go=%b ch=%b st=%0d", cpu_reset, frame_tick, score_p1, score_p2, game_over, champion, state_dbg);
    end
    reset = 1; tick();
    n_checks++;
    if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL idle_hold got %0d exp 0", state_dbg); end
  endtask

  task automatic test_start_serve();
    int ft;
    start = 1; tick(); start = 0; tick();
    n_checks++;
    if (state_dbg !== 3'd1 || cpu_reset !== 1'b1 || score_p1 !== 0 || score_p2 !== 0) begin
      n_fail++; $display("FAIL start_serve got st=%0d cr=%b s1=%0d s2=%0d exp 1 1 0 0", state_dbg, cpu_reset, score_p1, score_p2);
    end
    ft = 0;
    for (int i = 0; i < 59; i++) begin pe = 1; tick(); ft += frame_tick; pe = 0; tick(); end
    n_checks++;
    if (state_dbg !== 3'd1 || ft != 0) begin n_fail++; $display("FAIL serve_59 got st=%0d ticks=%0d exp 1 0", state_dbg, ft); end
    pulse_frame();
    n_checks++;
    if (state_dbg !== 3'd2 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL serve_60 got st=%0d cr=%b exp 2 0", state_dbg, cpu_reset); end
    pe = 1; tick(); pe = 0;
    n_checks++;
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL tick_fwd got %b exp 1", frame_tick); end
    tick();
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL tick_len got %b exp 0", frame_tick); end
  endtask

  task automatic test_point_p1();
    winner = 2'b01; tick(); winner = 0;
    n_checks++;
    if (state_dbg !== 3'd4 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL p1_point got st=%0d cr=%b exp 4 1", state_dbg, cpu_reset); end
    tick();
    n_checks++;
    if (state_dbg !== 3'd1 || score_p1 !== 4'd1 || score_p2 !== 4'd0) begin
      n_fail++; $display("FAIL p1_score got st=%0d s1=%0d s2=%0d exp 1 1 0", state_dbg, score_p1, score_p2);
    end
    for (int i = 0; i < 59; i++) pulse_frame();
    n_checks++;
    if (state_dbg !== 3'd1 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reserve_hold got st=%0d cr=%b exp 1 1", state_dbg, cpu_reset); end
    pulse_frame();
    winner = 2'b11;
    for (int i = 0; i < 10; i++) pulse_frame();
    winner = 0;
    n_checks++;
    if (state_dbg !== 3'd2 || score_p1 !== 4'd1 || score_p2 !== 4'd0) begin
      n_fail++; $display("FAIL winner_11 got st=%0d s1=%0d s2=%0d exp 2 1 0", state_dbg, score_p1, score_p2);
    end
  endtask

  task automatic test_pause();
    int ft;
    pause = 1; pe = 1; tick(); pause = 0; pe = 0;
    n_checks++;
    if (state_dbg !== 3'd3 || frame_tick !== 1'b1) begin n_fail++; $display("FAIL pause_enter got st=%0d ft=%b exp 3 1", state_dbg, frame_tick); end
    tick();
    ft = 0;
    for (int i = 0; i < 5; i++) begin pe = 1; tick(); ft += frame_tick; pe = 0; tick(); ft += frame_tick; end
    n_checks++;
    if (ft != 0 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL paused_ticks got ticks=%0d cr=%b exp 0 0", ft, cpu_reset); end
    winner = 2'b10; tick(); tick(); winner = 0;
    n_checks++;
    if (state_dbg !== 3'd3 || score_p2 !== 4'd0) begin n_fail++; $display("FAIL paused_winner got st=%0d s2=%0d exp 3 0", state_dbg, score_p2); end
    pause = 1; tick(); pause = 0; tick();
    n_checks++;
    if (state_dbg !== 3'd2) begin n_fail++; $display("FAIL resume got %0d exp 2", state_dbg); end
    pe = 1; tick(); pe = 0;
    n_checks++;
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick got %b exp 1", frame_tick); end
    tick();
  endtask

  task automatic test_point_vs_pause();
    pause = 1; winner = 2'b10; tick(); pause = 0; winner = 0;
    n_checks++;
    if (state_dbg !== 3'd4) begin n_fail++; $display("FAIL collide_point got %0d exp 4", state_dbg); end
    tick();
    n_checks++;
    if (state_dbg !== 3'd1 || score_p2 !== 4'd1 || score_p1 !== 4'd1) begin
      n_fail++; $display("FAIL collide_score got st=%0d s1=%0d s2=%0d exp 1 1 1", state_dbg, score_p1, score_p2);
    end
  endtask

  task automatic test_match_over();
    for (int i = 0; i < 5; i++) score_point(2'b10);
    n_checks++;
    if (state_dbg !== 3'd1 || score_p2 !== 4'd6 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL before_win got st=%0d s2=%0d go=%b exp 1 6 0", state_dbg, score_p2, game_over);
    end
    score_point(2'b10);
    n_checks++;
    if (state_dbg !== 3'd5 || game_over !== 1'b1 || champion !== 2'b10 || score_p2 !== 4'd7 || score_p1 !== 4'd1 || cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL over got st=%0d go=%b ch=%b s1=%0d s2=%0d cr=%b exp 5 1 10 1 7 1", state_dbg, game_over, champion, score_p1, score_p2, cpu_reset);
    end
    start = 1; tick(); start = 0;
    n_checks++;
    if (state_dbg !== 3'd1 || score_p1 !== 0 || score_p2 !== 0 || champion !== 2'b00 || game_over !== 1'b0) begin
      n_fail++; $display("FAIL rematch got st=%0d s1=%0d s2=%0d ch=%b go=%b exp 1 0 0 00 0", state_dbg, score_p1, score_p2, champion, game_over);
    end
    tick();
  endtask

  task automatic test_reset_mid_play();
    score_point(2'b01); score_point(2'b10); score_point(2'b01);
    score_point(2'b10); score_point(2'b01);
    serve_to_play();
    n_checks++;
    if (state_dbg !== 3'd2 || score_p1 !== 4'd3 || score_p2 !== 4'd2) begin
      n_fail++; $display("FAIL pre_reset got st=%0d s1=%0d s2=%0d exp 2 3 2", state_dbg, score_p1, score_p2);
    end
    #1 reset = 0;
    #1;
    n_checks++;
    if ({cpu_reset, frame_tick, score_p1, score_p2, game_over, champion, state_dbg} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset got cr=%b ft=%b s1=%0d s2=%0d go=%b ch=%b st=%0d", cpu_reset, frame_tick, score_p1, score_p2, game_over, champion, state_dbg);
    end
    tick();
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_point_p1();
    test_pause();
    test_point_vs_pause();
    test_match_over();
    test_reset_mid_play();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
